// File: rtl/vector_lsu_mp.sv
// Multi-port masked unit-stride/indexed vector LSU: issues up to PORTS lane requests per cycle, gathers tagged loads.
// Full 8-lane op on 2 ports: requests in cycles 1-4 after accept; mem_req_ready_i low freezes the slots, result_ready_i low holds DONE.
module vector_lsu_mp #(
    parameter int LANES  = 8,
    parameter int ELEM_W = 64,
    parameter int ADDR_W = 64,
    parameter int PORTS  = 2,
    parameter int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      is_store_i,
    input  logic                      indexed_i,
    input  logic [LANES-1:0]          mask_i,
    input  logic [ADDR_W-1:0]         base_addr_i,
    input  logic [LANES*ADDR_W-1:0]   index_i,
    input  logic [2:0]                scale_i,
    input  logic [LANES*ELEM_W-1:0]   store_data_i,
    output logic [PORTS-1:0]          mem_req_valid_o,
    input  logic                      mem_req_ready_i,
    output logic                      mem_req_we_o,
    output logic [PORTS*ADDR_W-1:0]   mem_req_addr_o,
    output logic [PORTS*ELEM_W-1:0]   mem_req_wdata_o,
    output logic [PORTS*LW-1:0]       mem_req_lane_o,
    input  logic [PORTS-1:0]          mem_resp_valid_i,
    input  logic [PORTS*LW-1:0]       mem_resp_lane_i,
    input  logic [PORTS*ELEM_W-1:0]   mem_resp_data_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic                      result_store_o,
    output logic [LANES*ELEM_W-1:0]   load_data_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state, state_nxt;

    logic                           is_store_q;
    logic                           indexed_q;
    logic [ADDR_W-1:0]              base_q;
    logic [LANES-1:0][ADDR_W-1:0]   index_q;
    logic [2:0]                     scale_q;
    logic [LANES-1:0][ELEM_W-1:0]   wdata_q;
    logic [LANES-1:0][ELEM_W-1:0]   data_q;
    logic [LANES-1:0][ELEM_W-1:0]   data_nxt;
    logic [LANES-1:0]               issue_pend;
    logic [LANES-1:0]               outst;
    logic [LANES-1:0]               outst_nxt;
    logic [LANES-1:0]               issued;
    logic [LANES-1:0][LW:0]         rank;
    logic [LANES-1:0][ADDR_W-1:0]   lane_addr;

    logic [PORTS-1:0]               slot_vld;
    logic [PORTS-1:0][ADDR_W-1:0]   slot_addr;
    logic [PORTS-1:0][ELEM_W-1:0]   slot_wdata;
    logic [PORTS-1:0][LW-1:0]       slot_lane;
    logic [PORTS-1:0][LW-1:0]       resp_lane;
    logic [PORTS-1:0][ELEM_W-1:0]   resp_data;

    logic accept;
    logic resp_en;
    logic issue_last;

    assign resp_lane  = mem_resp_lane_i;
    assign resp_data  = mem_resp_data_i;
    assign accept     = valid_i && (state == IDLE);
    assign resp_en    = ((state == ISSUE) || (state == WAIT)) && !is_store_q;
    assign issue_last = mem_req_ready_i && ((issue_pend & ~issued) == '0);

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (indexed_q)
                lane_addr[i] = base_q + (index_q[i] << scale_q);
            else
                lane_addr[i] = base_q + ADDR_W'(i) * ADDR_W'(ELEM_W / 8);
        end
    end

    // rank[i] = number of pending lanes below i; lanes ranked under PORTS go out this cycle.
    always_comb begin : rank_blk
        logic [LW:0] acc;
        acc    = '0;
        rank   = '0;
        issued = '0;
        for (int i = 0; i < LANES; i++) begin
            rank[i]   = acc;
            issued[i] = issue_pend[i] && (acc < (LW+1)'(PORTS));
            acc       = acc + (LW+1)'(issue_pend[i]);
        end
    end

    always_comb begin
        slot_vld   = '0;
        slot_addr  = '0;
        slot_wdata = '0;
        slot_lane  = '0;
        for (int k = 0; k < PORTS; k++) begin
            for (int i = 0; i < LANES; i++) begin
                if (issue_pend[i] && (rank[i] == (LW+1)'(k))) begin
                    slot_vld[k]   = 1'b1;
                    slot_addr[k]  = lane_addr[i];
                    slot_wdata[k] = is_store_q ? wdata_q[i] : '0;
                    slot_lane[k]  = LW'(i);
                end
            end
        end
    end

    // Descending slot order so the lowest slot's write is the one that sticks.
    always_comb begin
        outst_nxt = outst;
        data_nxt  = data_q;
        if (resp_en) begin
            for (int s = PORTS - 1; s >= 0; s--) begin
                if (mem_resp_valid_i[s] && outst[resp_lane[s]]) begin
                    data_nxt[resp_lane[s]]  = resp_data[s];
                    outst_nxt[resp_lane[s]] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (valid_i)
                    state_nxt = (mask_i == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (issue_last) begin
                    if (is_store_q || (outst_nxt == '0))
                        state_nxt = DONE;
                    else
                        state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (outst_nxt == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                if (result_ready_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_o         = (state == IDLE);
        mem_req_valid_o = '0;
        mem_req_we_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_wdata_o = '0;
        mem_req_lane_o  = '0;
        result_valid_o  = 1'b0;
        result_store_o  = 1'b0;
        load_data_o     = '0;
        if (state == ISSUE) begin
            mem_req_valid_o = slot_vld;
            mem_req_we_o    = is_store_q;
            mem_req_addr_o  = slot_addr;
            mem_req_wdata_o = slot_wdata;
            mem_req_lane_o  = slot_lane;
        end
        if (state == DONE) begin
            result_valid_o = 1'b1;
            result_store_o = is_store_q;
            load_data_o    = data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q <= 1'b0;
            indexed_q  <= 1'b0;
            base_q     <= '0;
            index_q    <= '0;
            scale_q    <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            issue_pend <= '0;
            outst      <= '0;
        end else if (accept) begin
            is_store_q <= is_store_i;
            indexed_q  <= indexed_i;
            base_q     <= base_addr_i;
            index_q    <= index_i;
            scale_q    <= scale_i;
            wdata_q    <= store_data_i;
            data_q     <= '0;
            issue_pend <= mask_i;
            outst      <= mask_i;
        end else begin
            if ((state == ISSUE) && mem_req_ready_i)
                issue_pend <= issue_pend & ~issued;
            outst  <= outst_nxt;
            data_q <= data_nxt;
        end
    end

endmodule
